cmd_ctrl: RTL and testbench
===========================

CMD_CTRL -- requirements
Module: cmd_ctrl

Interface
REQ-001 SHALL expose parameter DATA_W, default 8, which sets the width of the RX frame byte, register-file data and each FIFO word.
REQ-002 SHALL expose parameter ADDR_W, default 4, which sets the register-file address width.
REQ-003 SHALL expose parameter FUN_W, default 4, which sets the ALU function code width.
REQ-004 SHALL expose parameter RES_W, default 16, which sets the ALU result width; RES_W SHALL be a multiple of DATA_W, and NRES = RES_W/DATA_W.
REQ-005 SHALL provide port CLK, input, 1 bit: system clock, rising edge.
REQ-006 SHALL provide port RST, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL provide port RX_P_Data, input, DATA_W bits: received frame byte.
REQ-008 SHALL provide port RX_D_VLD, input, 1 bit: RX_P_Data is valid this cycle; pulses for one cycle per byte.
REQ-009 SHALL provide port Rd_D, input, DATA_W bits: register-file read data.
REQ-010 SHALL provide port Rd_D_Vld, input, 1 bit: Rd_D is valid.
REQ-011 SHALL provide port ALU_OUT, input, RES_W bits: ALU result.
REQ-012 SHALL provide port ALU_OUT_VLD, input, 1 bit: ALU_OUT is valid.
REQ-013 SHALL provide port F_FULL, input, 1 bit: TX FIFO full.
REQ-014 SHALL provide outputs CLK_G_EN (1), ALU_EN (1), ALU_FUN (FUN_W): ALU clock-gate enable, ALU enable and ALU function code.
REQ-015 SHALL provide outputs WrEn (1), RdEn (1), Address (ADDR_W), Wr_D (DATA_W): register-file access.
REQ-016 SHALL provide outputs W_INC (1), WR_DATA (DATA_W): FIFO write strobe and FIFO write data.
REQ-017 SHALL provide output BUSY (1): high when the block is not in IDLE.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 Commands (first byte in IDLE): 0xAA = write {addr, data}; 0xBB = read {addr}; 0xCC = ALU with operands {A, B, fun}; 0xDD = ALU without operands {fun}; any other value is ignored and the block stays in IDLE.
REQ-020 States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX.
REQ-021 Parameter bytes SHALL advance the FSM only on RX_D_VLD=1; without RX_D_VLD the FSM waits indefinitely.
REQ-022 Address SHALL be taken from RX_P_Data[ADDR_W-1:0]; upper bits SHALL be ignored.
REQ-023 Write: one cycle after the data byte, WrEn=1 for exactly 1 cycle, with the latched Address and Wr_D; the FSM then returns to IDLE.
REQ-024 Read: one cycle after the addr byte, RdEn=1 for 1 cycle, then RD_WAIT until Rd_D_Vld=1; Rd_D is captured into the TX buffer (1 word).
REQ-025 OP_A / OP_B: each byte SHALL be written to Address 0 / 1 respectively, with WrEn pulsed for 1 cycle, 1 cycle after the byte.
REQ-026 ALU_FUN: on the fun byte, ALU_FUN = RX_P_Data[FUN_W-1:0] and ALU_EN=1 for 1 cycle; CLK_G_EN=1 from that cycle until ALU_OUT_VLD is sampled.
REQ-027 ALU_WAIT: on ALU_OUT_VLD=1, ALU_OUT is captured as NRES words, least significant word first.
REQ-028 TX: W_INC=1 with WR_DATA = next word only in cycles where F_FULL=0; on F_FULL=1 the word is held and W_INC=0; IDLE is re-entered the cycle after the last word.
REQ-029 RX_D_VLD SHALL be ignored while in RD_WAIT, ALU_WAIT or TX, so bytes arriving there are dropped.
REQ-030 WrEn and RdEn SHALL never be asserted in the same cycle.
REQ-031 No timeout is provided; the wait states hold until the corresponding valid signal arrives.

Reset
REQ-032 RST low SHALL immediately force IDLE, including mid-command or mid-TX, with no partial resume after release.
REQ-033 On reset, all outputs, the TX buffer and the word counter SHALL be 0.

Verification
REQ-034 Write: AA,05,3C -> one cycle with WrEn=1, Address=5, Wr_D=0x3C; BUSY drops afterwards.
REQ-035 Read with F_FULL=0: BB,12 -> RdEn at Address=2; Rd_D=0x77 returned 3 cycles later -> one W_INC with WR_DATA=0x77.
REQ-036 ALU: CC,0A,03,00 -> writes 0x0A@0 and 0x03@1, ALU_EN with FUN=0; ALU_OUT=0x1234 -> W_INC twice with WR_DATA 0x34 then 0x12.
REQ-037 Backpressure: DD,02 with ALU_OUT=0xABCD and F_FULL=1 for 5 cycles -> no W_INC; after release, 0xCD then 0xAB.
REQ-038 Robustness: byte 0x55 in IDLE -> no output activity; RST pulsed in ALU_WAIT -> IDLE, all outputs 0, and a subsequent AA command executes normally.

Source files
------------

// File: rtl/cmd_ctrl.sv
// Command controller: decodes RX frame bytes into register-file writes/reads and ALU
// operations, then streams results into the TX FIFO least-significant word first.
module cmd_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int FUN_W  = 4,
    parameter int RES_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] RX_P_Data,
    input  logic              RX_D_VLD,
    input  logic [DATA_W-1:0] Rd_D,
    input  logic              Rd_D_Vld,
    input  logic [RES_W-1:0]  ALU_OUT,
    input  logic              ALU_OUT_VLD,
    input  logic              F_FULL,
    output logic              CLK_G_EN,
    output logic              ALU_EN,
    output logic [FUN_W-1:0]  ALU_FUN,
    output logic              WrEn,
    output logic              RdEn,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Wr_D,
    output logic              W_INC,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              BUSY,
    output logic [3:0]        o_fsm_state
);

    localparam int NRES  = RES_W / DATA_W;
    localparam int CNT_W = (NRES > 1) ? $clog2(NRES) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NRES - 1);

    localparam logic [DATA_W-1:0] CMD_WR      = DATA_W'(8'hAA);
    localparam logic [DATA_W-1:0] CMD_RD      = DATA_W'(8'hBB);
    localparam logic [DATA_W-1:0] CMD_ALU_OP  = DATA_W'(8'hCC);
    localparam logic [DATA_W-1:0] CMD_ALU_NOP = DATA_W'(8'hDD);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WR_ADDR  = 4'd1;
    localparam logic [3:0] S_WR_DATA  = 4'd2;
    localparam logic [3:0] S_RD_ADDR  = 4'd3;
    localparam logic [3:0] S_RD_WAIT  = 4'd4;
    localparam logic [3:0] S_OP_A     = 4'd5;
    localparam logic [3:0] S_OP_B     = 4'd6;
    localparam logic [3:0] S_ALU_FUN  = 4'd7;
    localparam logic [3:0] S_ALU_WAIT = 4'd8;
    localparam logic [3:0] S_TX       = 4'd9;

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [RES_W-1:0] r_buf;
    logic [CNT_W-1:0] r_cnt;

    assign o_fsm_state = r_state;

    // r_cnt holds the number of words still to send after the current one.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_Data == CMD_WR)           w_next = S_WR_ADDR;
                    else if (RX_P_Data == CMD_RD)      w_next = S_RD_ADDR;
                    else if (RX_P_Data == CMD_ALU_OP)  w_next = S_OP_A;
                    else if (RX_P_Data == CMD_ALU_NOP) w_next = S_ALU_FUN;
                end
            end
            S_WR_ADDR:  if (RX_D_VLD)    w_next = S_WR_DATA;
            S_WR_DATA:  if (RX_D_VLD)    w_next = S_IDLE;
            S_RD_ADDR:  if (RX_D_VLD)    w_next = S_RD_WAIT;
            S_RD_WAIT:  if (Rd_D_Vld)    w_next = S_TX;
            S_OP_A:     if (RX_D_VLD)    w_next = S_OP_B;
            S_OP_B:     if (RX_D_VLD)    w_next = S_ALU_FUN;
            S_ALU_FUN:  if (RX_D_VLD)    w_next = S_ALU_WAIT;
            S_ALU_WAIT: if (ALU_OUT_VLD) w_next = S_TX;
            S_TX:       if (!F_FULL && r_cnt == '0) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= S_IDLE;
            r_buf    <= '0;
            r_cnt    <= '0;
            CLK_G_EN <= 1'b0;
            ALU_EN   <= 1'b0;
            ALU_FUN  <= '0;
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            Address  <= '0;
            Wr_D     <= '0;
            W_INC    <= 1'b0;
            WR_DATA  <= '0;
            BUSY     <= 1'b0;
        end else begin
            r_state <= w_next;
            BUSY    <= (w_next != S_IDLE);
            WrEn    <= 1'b0;
            RdEn    <= 1'b0;
            ALU_EN  <= 1'b0;
            W_INC   <= 1'b0;
            case (r_state)
                S_WR_ADDR: if (RX_D_VLD) Address <= RX_P_Data[ADDR_W-1:0];
                S_WR_DATA: begin
                    if (RX_D_VLD) begin
                        Wr_D <= RX_P_Data;
                        WrEn <= 1'b1;
                    end
                end
                S_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        Address <= RX_P_Data[ADDR_W-1:0];
                        RdEn    <= 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    if (Rd_D_Vld) begin
                        r_buf <= RES_W'(Rd_D);
                        r_cnt <= '0;
                    end
                end
                S_OP_A: begin
                    if (RX_D_VLD) begin
                        Address <= '0;
                        Wr_D    <= RX_P_Data;
                        WrEn    <= 1'b1;
                    end
                end
                S_OP_B: begin
                    if (RX_D_VLD) begin
                        Address <= ADDR_W'(1);
                        Wr_D    <= RX_P_Data;
                        WrEn    <= 1'b1;
                    end
                end
                S_ALU_FUN: begin
                    if (RX_D_VLD) begin
                        ALU_FUN  <= RX_P_Data[FUN_W-1:0];
                        ALU_EN   <= 1'b1;
                        CLK_G_EN <= 1'b1;
                    end
                end
                S_ALU_WAIT: begin
                    if (ALU_OUT_VLD) begin
                        r_buf    <= ALU_OUT;
                        r_cnt    <= LAST_WORD;
                        CLK_G_EN <= 1'b0;
                    end
                end
                S_TX: begin
                    // A full FIFO stalls the stream with the current word held in r_buf.
                    if (!F_FULL) begin
                        W_INC   <= 1'b1;
                        WR_DATA <= r_buf[DATA_W-1:0];
                        r_buf   <= r_buf >> DATA_W;
                        if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_ctrl.sv
// Bench for cmd_ctrl: directed command table, timing sequences and random commands
// checked against a transaction-level model of the command protocol.
module tb_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_Data = '0;
    logic        RX_D_VLD = 1'b0;
    logic [7:0]  Rd_D = '0;
    logic        Rd_D_Vld = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VLD = 1'b0;
    logic        F_FULL = 1'b0;
    logic        CLK_G_EN, ALU_EN, WrEn, RdEn, W_INC, BUSY;
    logic [3:0]  ALU_FUN, Address, fsm_state;
    logic [7:0]  Wr_D, WR_DATA;

    cmd_ctrl dut (
        .CLK(CLK), .RST(RST), .RX_P_Data(RX_P_Data), .RX_D_VLD(RX_D_VLD),
        .Rd_D(Rd_D), .Rd_D_Vld(Rd_D_Vld), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .F_FULL(F_FULL), .CLK_G_EN(CLK_G_EN), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .Wr_D(Wr_D), .W_INC(W_INC),
        .WR_DATA(WR_DATA), .BUSY(BUSY), .o_fsm_state(fsm_state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0][7:0] b;
        int              nb;
        logic [7:0]      rd_d;
        logic [15:0]     alu;
        int              full_hold;
        int              junk;
        int              n_wr;
        logic [1:0][11:0] wr;
        int              n_rd;
        logic [3:0]      rd_a;
        int              n_alu;
        logic [3:0]      fun;
        int              n_tx;
        logic [1:0][7:0] tx;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int full_until = 0;
    bit full_rand = 0;
    bit full_prev = 0;
    int gap_max = 0;
    logic [11:0] obs_wr[$];
    logic [11:0] obs_rd[$];
    logic [11:0] obs_alu[$];
    logic [11:0] obs_tx[$];
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    always @(posedge CLK) begin
        cyc++;
        full_prev = F_FULL;
    end

    initial forever begin
        @(negedge CLK);
        F_FULL = (cyc < full_until) ? 1'b1 : (full_rand ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    always @(negedge CLK) begin
        if (RST) begin
            if (WrEn)   obs_wr.push_back({Address, Wr_D});
            if (RdEn)   obs_rd.push_back(12'(Address));
            if (ALU_EN) obs_alu.push_back(12'(ALU_FUN));
            if (W_INC) begin
                obs_tx.push_back(12'(WR_DATA));
                chk("winc_while_full", 32'(full_prev), 32'd0);
            end
            if (WrEn && RdEn) chk("wren_rden_overlap", 32'd1, 32'd0);
            if (ALU_EN)       chk("clk_gate_with_alu_en", 32'(CLK_G_EN), 32'd1);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_Data = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK);
        #1;
        RX_D_VLD  = 1'b0;
        RX_P_Data = 8'($urandom);
    endtask

    task automatic clear_obs();
        obs_wr.delete();
        obs_rd.delete();
        obs_alu.delete();
        obs_tx.delete();
    endtask

    task automatic pulse_reset();
        RST = 1'b0;
        idle(2);
        RST = 1'b1;
        idle(1);
    endtask

    task automatic check_q(input string name, input int n_exp, input logic [11:0] e0,
                           input logic [11:0] e1, input logic [11:0] got[$]);
        chk({name, "_count"}, 32'(got.size()), 32'(n_exp));
        for (int i = 0; i < got.size() && i < n_exp && i < 2; i++)
            chk(name, 32'(got[i]), 32'((i == 0) ? e0 : e1));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (BUSY !== 1'b0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_idle_timeout"}, 32'(n < 300), 32'd1);
        if (n >= 300) pulse_reset();
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, input int nb,
                                input logic [7:0] rd_d, input logic [15:0] alu,
                                input int fh, input int junk);
        vec_t v;
        v.b = {b3, b2, b1, b0};
        v.nb = nb;
        v.rd_d = rd_d;
        v.alu = alu;
        v.full_hold = fh;
        v.junk = junk;
        v.n_wr = 0;
        v.wr = '0;
        v.n_rd = 0;
        v.rd_a = '0;
        v.n_alu = 0;
        v.fun = '0;
        v.n_tx = 0;
        v.tx = '0;
        return v;
    endfunction

    // Transaction-level model: what each command must do to the register file, ALU and FIFO.
    function automatic vec_t predict(input vec_t v);
        vec_t r = v;
        case (v.b[0])
            8'hAA: begin
                r.n_wr = 1;
                r.wr[0] = {v.b[1][3:0], v.b[2]};
            end
            8'hBB: begin
                r.n_rd = 1;
                r.rd_a = v.b[1][3:0];
                r.n_tx = 1;
                r.tx[0] = v.rd_d;
            end
            8'hCC, 8'hDD: begin
                if (v.b[0] == 8'hCC) begin
                    r.n_wr = 2;
                    r.wr[0] = {4'd0, v.b[1]};
                    r.wr[1] = {4'd1, v.b[2]};
                end
                r.n_alu = 1;
                r.fun = (v.b[0] == 8'hCC) ? v.b[3][3:0] : v.b[1][3:0];
                r.n_tx = 2;
                r.tx[0] = v.alu[7:0];
                r.tx[1] = v.alu[15:8];
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        bit is_rd = (v.b[0] == 8'hBB);
        bit is_alu = (v.b[0] == 8'hCC) || (v.b[0] == 8'hDD);
        for (int i = 0; i < v.nb; i++) begin
            send_byte(v.b[i]);
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
        if (is_rd || is_alu) begin
            for (int j = 0; j < v.junk; j++) send_byte(8'hAA);
            idle($urandom_range(0, 3));
            if (v.full_hold > 0) full_until = cyc + v.full_hold + 1;
            if (is_rd) begin
                Rd_D = v.rd_d;
                Rd_D_Vld = 1'b1;
            end else begin
                ALU_OUT = v.alu;
                ALU_OUT_VLD = 1'b1;
            end
            @(posedge CLK);
            #1;
            Rd_D_Vld = 1'b0;
            ALU_OUT_VLD = 1'b0;
            if (v.full_hold >= 4)
                for (int j = 0; j < v.junk; j++) send_byte(8'hAA);
        end
        wait_idle(tag);
        check_q({tag, "_wr"}, v.n_wr, v.wr[0], v.wr[1], obs_wr);
        check_q({tag, "_rd"}, v.n_rd, 12'(v.rd_a), 12'h0, obs_rd);
        check_q({tag, "_alu"}, v.n_alu, 12'(v.fun), 12'h0, obs_alu);
        check_q({tag, "_tx"}, v.n_tx, 12'(v.tx[0]), 12'(v.tx[1]), obs_tx);
        clear_obs();
    endtask

    initial begin
        vec_t v;
        logic [7:0] cmd;

        tbl[0] = mk(8'hAA, 8'h05, 8'h3C, 8'h00, 3, 8'h00, 16'h0000, 0, 0);
        tbl[0].n_wr = 1; tbl[0].wr[0] = 12'h53C;
        tbl[1] = mk(8'hBB, 8'h12, 8'h00, 8'h00, 2, 8'h77, 16'h0000, 0, 1);
        tbl[1].n_rd = 1; tbl[1].rd_a = 4'h2; tbl[1].n_tx = 1; tbl[1].tx[0] = 8'h77;
        tbl[2] = mk(8'hCC, 8'h0A, 8'h03, 8'h00, 4, 8'h00, 16'h1234, 0, 2);
        tbl[2].n_wr = 2; tbl[2].wr[0] = 12'h00A; tbl[2].wr[1] = 12'h103;
        tbl[2].n_alu = 1; tbl[2].fun = 4'h0; tbl[2].n_tx = 2; tbl[2].tx[0] = 8'h34; tbl[2].tx[1] = 8'h12;
        tbl[3] = mk(8'hDD, 8'h02, 8'h00, 8'h00, 2, 8'h00, 16'hABCD, 5, 2);
        tbl[3].n_alu = 1; tbl[3].fun = 4'h2; tbl[3].n_tx = 2; tbl[3].tx[0] = 8'hCD; tbl[3].tx[1] = 8'hAB;
        tbl[4] = mk(8'h55, 8'h00, 8'h00, 8'h00, 1, 8'h00, 16'h0000, 0, 0);
        tbl[5] = mk(8'hAA, 8'hF9, 8'h81, 8'h00, 3, 8'h00, 16'h0000, 0, 0);
        tbl[5].n_wr = 1; tbl[5].wr[0] = 12'h981;
        tbl[6] = mk(8'hDD, 8'hF7, 8'h00, 8'h00, 2, 8'h00, 16'h00FF, 0, 0);
        tbl[6].n_alu = 1; tbl[6].fun = 4'h7; tbl[6].n_tx = 2; tbl[6].tx[0] = 8'hFF; tbl[6].tx[1] = 8'h00;

        // Reset state
        idle(3);
        chk("reset_outputs", {2'b0, CLK_G_EN, ALU_EN, ALU_FUN, WrEn, RdEn, Address, Wr_D,
                              W_INC, WR_DATA, BUSY}, 32'd0);
        chk("reset_state", 32'(fsm_state), 32'd0);
        RST = 1'b1;
        idle(2);

        // Directed table
        for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

        // Write pulse timing
        send_byte(8'hAA);
        send_byte(8'h05);
        chk("wr_busy_mid", 32'(BUSY), 32'd1);
        send_byte(8'h3C);
        chk("wr_pulse", {WrEn, RdEn, Address, Wr_D}, {2'b10, 4'h5, 8'h3C});
        chk("wr_busy_drop", 32'(BUSY), 32'd0);
        idle(1);
        chk("wr_single_cycle", 32'(WrEn), 32'd0);
        clear_obs();

        // Read pulse timing and 3-cycle response
        send_byte(8'hBB);
        send_byte(8'h12);
        chk("rd_pulse", {WrEn, RdEn, Address}, {2'b01, 4'h2});
        idle(1);
        chk("rd_single_cycle", 32'(RdEn), 32'd0);
        idle(1);
        Rd_D = 8'h77;
        Rd_D_Vld = 1'b1;
        idle(1);
        Rd_D_Vld = 1'b0;
        wait_idle("rd_seq");
        check_q("rd_seq_tx", 1, 12'h077, 12'h0, obs_tx);
        clear_obs();

        // ALU enable, clock gate, then reset while waiting for the ALU
        send_byte(8'hDD);
        send_byte(8'h02);
        chk("alu_en_pulse", {ALU_EN, CLK_G_EN, ALU_FUN}, {2'b11, 4'h2});
        idle(1);
        chk("alu_en_single", {ALU_EN, CLK_G_EN, BUSY}, 3'b011);
        idle(2);
        chk("alu_wait_gate", {CLK_G_EN, BUSY}, 2'b11);
        RST = 1'b0;
        #1;
        chk("async_reset_outputs", {2'b0, CLK_G_EN, ALU_EN, ALU_FUN, WrEn, RdEn, Address, Wr_D,
                                    W_INC, WR_DATA, BUSY}, 32'd0);
        chk("async_reset_state", 32'(fsm_state), 32'd0);
        idle(2);
        RST = 1'b1;
        idle(1);
        clear_obs();
        run_txn(tbl[0], "post_reset");

        // Random commands with random FIFO backpressure
        full_rand = 1;
        gap_max = 2;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: cmd = 8'hAA;
                1: cmd = 8'hBB;
                2: cmd = 8'hCC;
                3: cmd = 8'hDD;
                default: begin
                    cmd = 8'($urandom);
                    while (cmd == 8'hAA || cmd == 8'hBB || cmd == 8'hCC || cmd == 8'hDD)
                        cmd = 8'($urandom);
                end
            endcase
            v = mk(cmd, 8'($urandom), 8'($urandom), 8'($urandom),
                   (cmd == 8'hAA) ? 3 : (cmd == 8'hBB || cmd == 8'hDD) ? 2 : (cmd == 8'hCC) ? 4 : 1,
                   8'($urandom), 16'($urandom), 0, $urandom_range(0, 2));
            run_txn(predict(v), $sformatf("rnd%0d", n));
        end
        full_rand = 0;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
